// File: rtl/event_ctrl_pkg.sv
// Shared definitions for the event source controller.
// State encoding, default widths and synchronizer depth.
package event_ctrl_pkg;

    localparam logic [2:0] ENC_IDLE      = 3'd0;
    localparam logic [2:0] ENC_DRIVE     = 3'd1;
    localparam logic [2:0] ENC_WAIT_FREE = 3'd2;
    localparam logic [2:0] ENC_GAP       = 3'd3;
    localparam logic [2:0] ENC_DONE      = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = ENC_IDLE,
        ST_DRIVE     = ENC_DRIVE,
        ST_WAIT_FREE = ENC_WAIT_FREE,
        ST_GAP       = ENC_GAP,
        ST_DONE      = ENC_DONE
    } state_t;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_GAP_W   = 16;
    localparam int DEF_PULSE_W = 4;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/event_source_ctrl_sync_2ff.sv
// Two-flop synchronizer, async active-low reset.
// Reset value is a parameter so idle-high lines come up idle.
module sync_2ff
    import event_ctrl_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // shift the async input through the synchronizer chain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ff <= {SYNC_STAGES{RST_VAL}};
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/event_source_ctrl.sv
// Burst event source: active-low drive pulses, waits for sink free.
// Optional WAIT_FREE watchdog: define EVENT_SRC_TIMEOUT_EN.
module event_source_ctrl
    import event_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GAP_W       = DEF_GAP_W,
    parameter int PULSE_W     = DEF_PULSE_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_count,
    input  logic [GAP_W-1:0] i_gap,
    output logic             o_drive,
    input  logic             i_free,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_issued,
    output logic             o_timeout
);

    localparam int PC_W = $clog2(PULSE_W + 1);
    localparam logic [PC_W-1:0] PULSE_LAST = PC_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] ISSUED_MAX = '1;

`ifdef EVENT_SRC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt_lat;
    logic [GAP_W-1:0] gap_lat;
    logic [GAP_W-1:0] gap_cnt;
    logic [PC_W-1:0]  pulse_cnt;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] issued_next;
    logic             drive;
    logic             busy;
    logic             done;
    logic             stop_pending;
    logic             stop_now;
    logic             free_lat;
    logic             free_s;
    logic             free_q;
    logic             free_evt;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_free_sync (
        .clk (clk),
        .rstn(rstn),
        .d   (i_free),
        .q   (free_s)
    );

    // registered falling-edge detect on the synchronized free line
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            free_q   <= 1'b1;
            free_evt <= 1'b0;
        end else begin
            free_q   <= free_s;
            free_evt <= free_q & ~free_s;
        end
    end

    assign issued_next = (issued == ISSUED_MAX) ?
                         issued : issued + CNT_W'(1);
    assign stop_now    = stop_pending | i_stop;

    // burst sequencer with registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            cnt_lat      <= '0;
            gap_lat      <= '0;
            gap_cnt      <= '0;
            pulse_cnt    <= '0;
            issued       <= '0;
            drive        <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            stop_pending <= 1'b0;
            free_lat     <= 1'b0;
`ifdef EVENT_SRC_TIMEOUT_EN
            to_cnt       <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && i_stop) begin
                stop_pending <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    stop_pending <= 1'b0;
                    if (i_start && !i_stop) begin
                        cnt_lat  <= i_count;
                        gap_lat  <= i_gap;
                        issued   <= '0;
                        free_lat <= 1'b0;
                        busy     <= 1'b1;
`ifdef EVENT_SRC_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        if (i_count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_DRIVE;
                            drive     <= 1'b0;
                            pulse_cnt <= PULSE_LAST;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (free_evt) begin
                        free_lat <= 1'b1;
                    end
                    if (pulse_cnt == '0) begin
                        drive <= 1'b1;
                        state <= ST_WAIT_FREE;
`ifdef EVENT_SRC_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end else begin
                        pulse_cnt <= pulse_cnt - PC_W'(1);
                    end
                end
                ST_WAIT_FREE: begin
                    if (free_evt || free_lat) begin
                        free_lat <= 1'b0;
                        issued   <= issued_next;
                        if (issued_next == cnt_lat || stop_now) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (gap_lat == '0) begin
                            state     <= ST_DRIVE;
                            drive     <= 1'b0;
                            pulse_cnt <= PULSE_LAST;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= gap_lat - GAP_W'(1);
                        end
                    end
`ifdef EVENT_SRC_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= ST_DONE;
                        done      <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                ST_GAP: begin
                    if (stop_now) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (gap_cnt == '0) begin
                        state     <= ST_DRIVE;
                        drive     <= 1'b0;
                        pulse_cnt <= PULSE_LAST;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    drive <= 1'b1;
                end
            endcase
        end
    end

    assign o_drive  = drive;
    assign o_busy   = busy;
    assign o_done   = done;
    assign o_issued = issued;
`ifdef EVENT_SRC_TIMEOUT_EN
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_event_source_ctrl.sv
// Directed bench for event_source_ctrl with a behavioural sink.
// Vector table for bursts, hand sequences for corner cases.
module tb_event_source_ctrl;

    localparam int CNT_W       = 16;
    localparam int GAP_W       = 16;
    localparam int PULSE_W     = 4;
    localparam int TIMEOUT_CYC = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic             i_start;
    logic             i_stop;
    logic [CNT_W-1:0] i_count;
    logic [GAP_W-1:0] i_gap;
    logic             o_drive;
    logic             i_free;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_issued;
    logic             o_timeout;

    event_source_ctrl #(
        .CNT_W      (CNT_W),
        .GAP_W      (GAP_W),
        .PULSE_W    (PULSE_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_start  (i_start),
        .i_stop   (i_stop),
        .i_count  (i_count),
        .i_gap    (i_gap),
        .o_drive  (o_drive),
        .i_free   (i_free),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_issued (o_issued),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        int gap;
        int delay;
        int hold;
        int stop_at;
        int exp_issued;
        int exp_pulses;
    } vec_t;

    vec_t vecs[7];

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pulses, dones, width, wmin, wmax;
    int free_at, free_rise, last_free, last_rise;
    int cur_gap, stop_at, sink_delay, sink_hold, budget;
    bit sink_en, drv_q, fall_now;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        pulses    = 0;
        dones     = 0;
        width     = 0;
        wmin      = 1000;
        wmax      = 0;
        free_at   = -1;
        free_rise = -1;
        last_free = -1;
        last_rise = -1;
        stop_at   = 0;
        drv_q     = o_drive;
    endtask

    task automatic step();
        int e;
        @(negedge clk);
        cyc++;
        fall_now = drv_q && !o_drive;
        if (fall_now) begin
            pulses++;
            width = 1;
            if (pulses > 1 && last_free >= 0) begin
                e = (last_free + 4 > last_rise + 1) ?
                    last_free + 4 : last_rise + 1;
                e = e + cur_gap;
                chk($sformatf("spacing_p%0d", pulses), cyc, e);
            end
            if (sink_en) free_at = cyc + sink_delay;
        end else if (!o_drive) begin
            width++;
        end
        if (!drv_q && o_drive) begin
            if (width < wmin) wmin = width;
            if (width > wmax) wmax = width;
            last_rise = cyc;
        end
        drv_q = o_drive;
        if (o_done === 1'b1) dones++;
        if (cyc == free_rise) i_free = 1'b1;
        if (cyc == free_at) begin
            i_free    = 1'b0;
            last_free = cyc;
            free_rise = cyc + sink_hold;
        end
        i_stop = (stop_at > 0 && fall_now && pulses == stop_at);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        clear_mon();
        cur_gap    = v.gap;
        stop_at    = v.stop_at;
        sink_delay = v.delay;
        sink_hold  = v.hold;
        sink_en    = 1'b1;
        i_count    = CNT_W'(v.count);
        i_gap      = GAP_W'(v.gap);
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        chk($sformatf("v%0d_busy_on", idx), o_busy, 1);
        budget = 0;
        while (dones == 0 && budget < 600) begin
            step();
            budget++;
        end
        chk($sformatf("v%0d_done_seen", idx), dones > 0, 1);
        repeat (4) step();
        chk($sformatf("v%0d_issued", idx), o_issued, v.exp_issued);
        chk($sformatf("v%0d_pulses", idx), pulses, v.exp_pulses);
        chk($sformatf("v%0d_dones", idx), dones, 1);
        chk($sformatf("v%0d_busy_off", idx), o_busy, 0);
        chk($sformatf("v%0d_drive_idle", idx), o_drive, 1);
        if (v.exp_pulses > 0) begin
            chk($sformatf("v%0d_wmin", idx), wmin, PULSE_W);
            chk($sformatf("v%0d_wmax", idx), wmax, PULSE_W);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_watchdog: simulation time limit hit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3, 2, 5, 4, 0, 3, 3};
        vecs[1] = '{2, 0, 5, 4, 0, 2, 2};
        vecs[2] = '{10, 1, 5, 4, 2, 2, 2};
        vecs[3] = '{3, 1, 1, 4, 0, 3, 3};
        vecs[4] = '{2, 0, 0, 3, 0, 2, 2};
        vecs[5] = '{1, 5, 3, 2, 0, 1, 1};
        vecs[6] = '{4, 3, 2, 2, 0, 4, 4};

        rstn    = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_count = '0;
        i_gap   = '0;
        i_free  = 1'b1;
        sink_en = 1'b0;
        cur_gap = 0;
        sink_delay = 0;
        sink_hold  = 1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        clear_mon();
        step();
        chk("rst_drive", o_drive, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_issued", o_issued, 0);
        chk("rst_timeout", o_timeout, 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        clear_mon();
        sink_en = 1'b0;
        i_count = '0;
        i_gap   = GAP_W'(3);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("zero_done_hi", o_done, 1);
        chk("zero_busy_hi", o_busy, 1);
        step();
        chk("zero_done_lo", o_done, 0);
        chk("zero_busy_lo", o_busy, 0);
        repeat (3) step();
        chk("zero_pulses", pulses, 0);
        chk("zero_dones", dones, 1);
        chk("zero_issued", o_issued, 0);

        clear_mon();
        i_free = 1'b0;
        repeat (5) step();
        i_free = 1'b1;
        repeat (6) step();
        chk("spur_busy", o_busy, 0);
        chk("spur_issued", o_issued, 0);
        run_vec('{1, 0, 2, 2, 0, 1, 1}, 90);

        clear_mon();
        i_stop  = 1'b1;
        i_start = 1'b1;
        i_count = CNT_W'(3);
        i_gap   = '0;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) step();
        chk("coll_busy", o_busy, 0);
        chk("coll_pulses", pulses, 0);
        chk("coll_dones", dones, 0);

        clear_mon();
        sink_en    = 1'b1;
        cur_gap    = 3;
        sink_delay = 5;
        sink_hold  = 2;
        i_count    = CNT_W'(5);
        i_gap      = GAP_W'(3);
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        budget = 0;
        while (o_issued !== CNT_W'(1) && budget < 100) begin
            step();
            budget++;
        end
        sink_en = 1'b0;
        repeat (12) step();
        chk("mid_issued", o_issued, 1);
        chk("mid_busy", o_busy, 1);
        chk("mid_pulses", pulses, 2);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_drive", o_drive, 1);
        chk("arst_busy", o_busy, 0);
        chk("arst_issued", o_issued, 0);
        chk("arst_done", o_done, 0);
        @(negedge clk);
        rstn   = 1'b1;
        i_free = 1'b1;
        clear_mon();
        repeat (3) step();
        chk("post_rst_busy", o_busy, 0);
        chk("post_rst_pulses", pulses, 0);

`ifdef EVENT_SRC_TIMEOUT_EN
        clear_mon();
        sink_en = 1'b0;
        cur_gap = 0;
        i_count = CNT_W'(2);
        i_gap   = '0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        budget = 0;
        while (dones == 0 && budget < 200) begin
            step();
            budget++;
        end
        chk("to_flag", o_timeout, 1);
        chk("to_issued", o_issued, 0);
        chk("to_pulses", pulses, 1);
        step();
        chk("to_busy_off", o_busy, 0);
        chk("to_dones", dones, 1);
        chk("to_sticky", o_timeout, 1);
        run_vec('{1, 0, 5, 4, 0, 1, 1}, 91);
        chk("to_cleared", o_timeout, 0);
`else
        chk("no_timeout", o_timeout, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_fail);
        $finish;
    end

endmodule
